// File: rtl/rsa_modexp_core.sv
// Modular exponentiation base^exp mod n via left-to-right square-and-multiply on a
// bit-serial interleaved multiplier. Optional feature macro: RSA_CORE_LOAD_ABORT_EN.
module rsa_modexp_core #(
  parameter int WIDTH = 8
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             core_load,
  input  logic [WIDTH-1:0] core_din,
  output logic             core_done,
  output logic             core_err,
  output logic [WIDTH-1:0] core_dout,
  output logic             core_busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic [WIDTH-1:0] x_q, x_d, r_q, r_d, p_q, p_d, dout_q, dout_d;
  logic [CW-1:0]    cnt_q, cnt_d, ptr_q, ptr_d;
  logic             done_q, done_d, err_q, err_d;

  // One multiplier step: P <- (2P + a_i*b) mod N; 2P + b < 3N fits in WIDTH+2 bits.
  logic [WIDTH-1:0] mul_a, mul_b, p_step;
  logic [WIDTH+1:0] acc, acc1, acc2, mod_ext;

  always_comb begin
    mul_a = r_q;
    mul_b = r_q;
    if (state_q == REDUCE) begin
      mul_a = base_q;
      mul_b = WIDTH'(1);
    end else if (state_q == MULT) begin
      mul_b = x_q;
    end
    mod_ext = {2'b00, mod_q};
    acc     = {1'b0, p_q, 1'b0} + (mul_a[cnt_q] ? {2'b00, mul_b} : '0);
    acc1    = (acc  >= mod_ext) ? acc  - mod_ext : acc;
    acc2    = (acc1 >= mod_ext) ? acc1 - mod_ext : acc1;
    p_step  = acc2[WIDTH-1:0];
  end

  // NOTE: every next-value is defaulted to its current value first, so no path
  // through the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    x_d     = x_q;
    r_d     = r_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    done_d  = done_q;
    err_d   = err_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE, DONE: begin
        if (core_load) begin
          state_d = IDLE;
          done_d  = 1'b0;
          err_d   = 1'b0;
          case (idx_q)
            2'd0: begin
              base_d = core_din;
              idx_d  = 2'd1;
            end
            2'd1: begin
              exp_d = core_din;
              idx_d = 2'd2;
            end
            default: begin
              mod_d = core_din;
              idx_d = 2'd0;
              if (core_din < WIDTH'(2)) begin
                state_d = DONE;
                done_d  = 1'b1;
                err_d   = 1'b1;
                dout_d  = '0;
              end else begin
                state_d = REDUCE;
                p_d     = '0;
                cnt_d   = CW'(WIDTH - 1);
              end
            end
          endcase
        end
      end
      default: begin
        p_d   = p_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          p_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          if (state_q == REDUCE) begin
            x_d     = p_step;
            r_d     = WIDTH'(1);
            ptr_d   = CW'(WIDTH - 1);
            state_d = SQUARE;
          end else begin
            r_d = p_step;
            // A set exponent bit after its square triggers the multiply by X.
            if (state_q == SQUARE && exp_q[ptr_q]) begin
              state_d = MULT;
            end else if (ptr_q == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
              dout_d  = p_step;
            end else begin
              ptr_d   = ptr_q - 1'b1;
              state_d = SQUARE;
            end
          end
        end
`ifdef RSA_CORE_LOAD_ABORT_EN
        if (core_load) begin
          state_d = IDLE;
          base_d  = core_din;
          idx_d   = 2'd1;
          done_d  = 1'b0;
          dout_d  = dout_q;
        end
`endif
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; the operand/work registers are reset too for a known start.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      x_q     <= '0;
      r_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      x_q     <= x_d;
      r_q     <= r_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  assign core_done = done_q;
  assign core_err  = err_q;
  assign core_dout = dout_q;
  assign core_busy = (state_q == REDUCE) || (state_q == SQUARE) || (state_q == MULT);
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: fixed and random operand sets checked against an
// arithmetic reference for value, latency, busy/err behaviour, reset and load-while-busy.
module tb_rsa_modexp_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         done, err, busy;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  rsa_modexp_core #(.WIDTH(W)) dut (
    .core_clk  (clk),
    .core_rst  (rst),
    .core_load (load),
    .core_din  (din),
    .core_done (done),
    .core_err  (err),
    .core_dout (dout),
    .core_busy (busy)
  );

  always #5 clk = ~clk;

  // Reference: repeated multiplication, independent of bit order or step count.
  function automatic logic [W-1:0] ref_modexp(input int unsigned b, e, n);
    longint unsigned r = 1 % n;
    longint unsigned bb = b % n;
    for (int unsigned k = 0; k < e; k++) r = (r * bb) % n;
    return W'(r);
  endfunction

  function automatic int ref_latency(input logic [W-1:0] e);
    return W * (1 + W + $countones(e));
  endfunction

  task automatic expect_eq(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Returns #1 after the capturing edge.
  task automatic load_word(input logic [W-1:0] d);
    @(negedge clk);
    load = 1'b1;
    din  = d;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic start_op(input logic [W-1:0] b, e, n);
    load_word(b);
    load_word(e);
    load_word(n);
  endtask

  // Called #1 after the modulus edge; pulse_at >= 0 strobes load=3 during the run.
  task automatic wait_done(input string name, input int lat, input logic [W-1:0] expv,
                           input int pulse_at);
    int cyc = 0;
    bit seen = 0;
    int busy_bad = 0;
    int dout_bad = 0;
    logic [W-1:0] prev = dout;
    if (busy !== 1'b1) busy_bad++;
    while (!seen && cyc < lat + 50) begin
      if (cyc == pulse_at) begin
        load = 1'b1;
        din  = 8'h03;
      end
      @(posedge clk);
      #1;
      load = 1'b0;
      cyc++;
      if (done === 1'b1) seen = 1;
      else begin
        if (busy !== 1'b1) busy_bad++;
        if (dout !== prev) dout_bad++;
      end
    end
    expect_eq({name, " latency"}, seen ? cyc : -1, lat);
    expect_eq({name, " dout"}, dout, expv);
    expect_eq({name, " err"}, err, 0);
    expect_eq({name, " busy during run (bad cycles)"}, busy_bad, 0);
    expect_eq({name, " dout held before done (bad cycles)"}, dout_bad, 0);
    expect_eq({name, " busy at done"}, busy, 0);
  endtask

  task automatic run_case(input string name, input logic [W-1:0] b, e, n);
    start_op(b, e, n);
    wait_done(name, ref_latency(e), ref_modexp(b, e, n), -1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_eq("reset done", done, 0);
    expect_eq("reset err", err, 0);
    expect_eq("reset dout", dout, 0);
    expect_eq("reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    run_case("7^5 mod 13", 8'd7, 8'd5, 8'd13);
    expect_eq("7^5 mod 13 literal", dout, 8'h0B);
    run_case("200^3 mod 7", 8'd200, 8'd3, 8'd7);
    run_case("9^0 mod 11", 8'd9, 8'd0, 8'd11);
    run_case("250^2 mod 251", 8'd250, 8'd2, 8'd251);
    run_case("255^255 mod 255", 8'd255, 8'd255, 8'd255);
  endtask

  task automatic test_invalid_modulus;
    start_op(8'd5, 8'd3, 8'd1);
    expect_eq("mod1 done", done, 1);
    expect_eq("mod1 err", err, 1);
    expect_eq("mod1 dout", dout, 0);
    expect_eq("mod1 busy", busy, 0);
    load_word(8'd5);
    expect_eq("mod0 first load clears done", done, 0);
    load_word(8'd3);
    expect_eq("mod0 busy before capture", busy, 0);
    load_word(8'd0);
    expect_eq("mod0 done", done, 1);
    expect_eq("mod0 err", err, 1);
    expect_eq("mod0 dout", dout, 0);
    expect_eq("mod0 busy", busy, 0);
    load_word(8'd7);
    expect_eq("valid after err clears err", err, 0);
    load_word(8'd5);
    load_word(8'd13);
    wait_done("after err 7^5 mod 13", 88, 8'h0B, -1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] b = W'($urandom_range(0, 255));
      logic [W-1:0] e = W'($urandom_range(0, 255));
      logic [W-1:0] n = W'($urandom_range(2, 255));
      run_case($sformatf("rand%0d %0d^%0d mod %0d", i, b, e, n), b, e, n);
    end
  endtask

  task automatic test_reset_midrun;
    start_op(8'd7, 8'd5, 8'd13);
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    expect_eq("async reset done", done, 0);
    expect_eq("async reset err", err, 0);
    expect_eq("async reset dout", dout, 0);
    expect_eq("async reset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_case("reload 7^5 mod 13", 8'd7, 8'd5, 8'd13);
  endtask

  task automatic test_load_while_busy;
`ifdef RSA_CORE_LOAD_ABORT_EN
    int early_done = 0;
    start_op(8'd7, 8'd5, 8'd13);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) early_done++;
    end
    load = 1'b1;
    din  = 8'h03;
    @(posedge clk);
    #1;
    load = 1'b0;
    expect_eq("abort busy drops", busy, 0);
    expect_eq("abort no done", done, 0);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) early_done++;
    end
    expect_eq("abort done never seen (cycles)", early_done, 0);
    load_word(8'd4);
    load_word(8'd13);
    wait_done("after abort 3^4 mod 13", ref_latency(8'd4), ref_modexp(3, 4, 13), -1);
`else
    start_op(8'd7, 8'd5, 8'd13);
    wait_done("ignored load 7^5 mod 13", 88, 8'h0B, 40);
    run_case("after ignored load 11^7 mod 23", 8'd11, 8'd7, 8'd23);
`endif
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_invalid_modulus();
    test_random();
    test_reset_midrun();
    test_load_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
